eth_tx_serializer: RTL

//  RMII transmit datapath driven by eth_tx_ctrl. Each Clk cycle it turns the controller state into one

---
 rtl/eth_tx_serializer_if.sv | 33 +++
 rtl/eth_tx_serializer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/eth_tx_serializer_if.sv
// eth_tx_serializer_if: controller-side inputs and RMII pin outputs of eth_tx_serializer.
// The statistics signals exist only when ETH_TX_STATS_EN is defined.
interface eth_tx_serializer_if;
  logic [3:0]  Tx_Ctrl_FSM_State;
  logic        Tx_En;
  logic        Crc_En;
  logic [47:0] Dest_Addr;
  logic [47:0] Src_Addr;
  logic [15:0] Len_Type;
  logic [7:0]  Fifo_Data;
  logic [1:0]  Txd;
  logic        Txd_En;
`ifdef ETH_TX_STATS_EN
  logic [15:0] Frame_Cnt;
  logic [10:0] Last_Len;
`endif

  modport master (
    output Tx_Ctrl_FSM_State, Tx_En, Crc_En, Dest_Addr, Src_Addr, Len_Type, Fifo_Data,
    input  Txd, Txd_En
`ifdef ETH_TX_STATS_EN
    , input Frame_Cnt, Last_Len
`endif
  );

  modport slave (
    input  Tx_Ctrl_FSM_State, Tx_En, Crc_En, Dest_Addr, Src_Addr, Len_Type, Fifo_Data,
    output Txd, Txd_En
`ifdef ETH_TX_STATS_EN
    , output Frame_Cnt, Last_Len
`endif
  );
endinterface

// File: rtl/eth_tx_serializer.sv
// eth_tx_serializer: RMII transmit datapath. Turns the controller state into one dibit
// per clock (preamble, SFD, header, payload, pad, FCS), keeps the running CRC-32 and
// drives registered TXD/TX_EN. Optional ETH_TX_STATS_EN adds Frame_Cnt/Last_Len.
module eth_tx_serializer #(
  parameter int unsigned pPreamble_Dibits = 28,
  parameter int unsigned pSFD_Dibits      = 4,
  parameter int unsigned pFCS_Dibits      = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  eth_tx_serializer_if.slave bus
);
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_SFD      = 4'd2,
    ST_DEST     = 4'd3,
    ST_SRC      = 4'd4,
    ST_LEN_TYPE = 4'd5,
    ST_DATA     = 4'd6,
    ST_PAD      = 4'd7,
    ST_FCS      = 4'd8
  } tx_state_e;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  tx_state_e   state;
  tx_state_e   state_d;
  logic [7:0]  idx;
  logic [7:0]  idx_r;
  logic [7:0]  byte_r;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [47:0] addr_sel;
  logic [1:0]  nd;
  logic        crc_upd;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY : '0);
  endfunction

  // Decode controller state; unknown codes behave as IDLE
  always_comb begin
    if (bus.Tx_Ctrl_FSM_State > 4'd8) state = ST_IDLE;
    else                              state = tx_state_e'(bus.Tx_Ctrl_FSM_State);
  end

  // Dibit index: restarts on state change, wraps 0..3 in DATA, saturates elsewhere
  always_comb begin
    idx = '0;
    if (state == state_d) begin
      if (state == ST_DATA)    idx = {6'd0, idx_r[1:0] + 2'd1};
      else if (idx_r != '1)    idx = idx_r + 8'd1;
      else                     idx = idx_r;
    end
  end

  // Next dibit; header fields go byte by byte, LSB dibit first within each byte
  always_comb begin
    nd       = 2'b00;
    addr_sel = (state == ST_SRC) ? bus.Src_Addr : bus.Dest_Addr;
    unique case (state)
      ST_PREAMBLE: if (32'(idx) < pPreamble_Dibits) nd = 2'b01;
      ST_SFD:      if (32'(idx) < pSFD_Dibits)
                     nd = (32'(idx) == pSFD_Dibits - 1) ? 2'b11 : 2'b01;
      // byte b = idx/4 sits at bits 8*(5-b); dibit j adds 2*j
      ST_DEST,
      ST_SRC:      if (idx < 8'd24)
                     nd = addr_sel[{3'(3'd5 - idx[4:2]), idx[1:0], 1'b0} +: 2];
      ST_LEN_TYPE: if (idx < 8'd8)
                     nd = bus.Len_Type[{~idx[2], idx[1:0], 1'b0} +: 2];
      ST_DATA:     nd = (idx[1:0] == 2'd0) ? bus.Fifo_Data[1:0] : byte_r[{idx[1:0], 1'b0} +: 2];
      ST_FCS:      if (32'(idx) < pFCS_Dibits) nd = ~crc[{idx[3:0], 1'b0} +: 2];
      default:     nd = 2'b00;
    endcase
  end

  // Two reflected CRC steps per cycle, nd[0] first; only header/payload/pad states feed it
  always_comb begin
    crc_next = crc_step(crc_step(crc, nd[0]), nd[1]);
    crc_upd  = bus.Crc_En && (state inside {ST_DEST, ST_SRC, ST_LEN_TYPE, ST_DATA, ST_PAD});
  end

  // State history, dibit index and payload byte latch
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_d <= ST_IDLE;
      idx_r   <= '0;
      byte_r  <= '0;
    end else begin
      state_d <= state;
      idx_r   <= idx;
      if (state == ST_DATA && idx[1:0] == 2'd0) byte_r <= bus.Fifo_Data;
    end
  end

  // Running CRC: preset in IDLE, held through FCS
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                crc <= '1;
    else if (state == ST_IDLE) crc <= '1;
    else if (crc_upd)          crc <= crc_next;
  end

  // Registered RMII pins
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.Txd    <= '0;
      bus.Txd_En <= 1'b0;
    end else begin
      bus.Txd    <= bus.Tx_En ? nd : 2'b00;
      bus.Txd_En <= bus.Tx_En;
    end
  end

`ifdef ETH_TX_STATS_EN
  logic [12:0] dib_cnt;
  logic        aborted;
  logic        frame_done;

  assign frame_done = (state_d == ST_FCS) && (state == ST_IDLE);

  // Frame statistics: dibits counted from DEST onward, published on FCS->IDLE unless Tx_En dropped
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.Frame_Cnt <= '0;
      bus.Last_Len  <= '0;
      dib_cnt       <= '0;
      aborted       <= 1'b0;
    end else begin
      if (frame_done && !aborted) begin
        bus.Frame_Cnt <= bus.Frame_Cnt + 16'd1;
        bus.Last_Len  <= dib_cnt[12:2];
      end
      if (state == ST_IDLE) begin
        dib_cnt <= '0;
        aborted <= 1'b0;
      end else begin
        if (state inside {ST_DEST, ST_SRC, ST_LEN_TYPE, ST_DATA, ST_PAD, ST_FCS})
          dib_cnt <= dib_cnt + 13'd1;
        if (!bus.Tx_En) aborted <= 1'b1;
      end
    end
  end
`endif
endmodule
